// File: rtl/pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen_pkg
// Description : Shared mode codes, config field positions, dither table and
//               colour-bar mapping for the VGA test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_gen_pkg;

  // Pattern mode codes (cfg[6:4])
  localparam logic [2:0] MODE_PASS  = 3'd0;
  localparam logic [2:0] MODE_RAMP  = 3'd1;
  localparam logic [2:0] MODE_BARS  = 3'd2;
  localparam logic [2:0] MODE_XORS  = 3'd3;
  localparam logic [2:0] MODE_CHECK = 3'd4;

  // Config byte layout: [7] reserved, [6:4] mode, [3:2] divider, [1:0] primary
  localparam int CFG_MODE_MSB = 6;
  localparam int CFG_MODE_LSB = 4;
  localparam int CFG_DIV_MSB  = 3;
  localparam int CFG_DIV_LSB  = 2;
  localparam int CFG_PRI_MSB  = 1;
  localparam int CFG_PRI_LSB  = 0;

  // 2x2 ordered-dither threshold, indexed by {vpos[0], hpos[0]}
  function automatic logic [1:0] bayer_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd0;
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // Bar index (0 = leftmost) to {r,g,b} on/off bits; bar 0 is white, 7 black
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    c = 3'd7 - idx;
    return {c[1], c[2], c[0]};
  endfunction

  // 8-bit add that clamps at 255 instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [9:0] a);
    logic [9:0] s;
    s = {2'b00, v} + a;
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pipe
// Description : Parametrised-depth register delay line with a configurable
//               reset value. Used to delay-match syncs/blank and colour data.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_pipe #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift the input through DEPTH register stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen
// Description : VGA test-pattern generator. Frame-boundary config loading,
//               PASS/RAMP/BARS/XORS/CHECKER patterns, BPC truncation, and a
//               PIPE-deep output register with delay-matched syncs and blank.
//               Optional ordered 2x2 dither: define PATTERN_GEN_DITHER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen #(
  parameter int         BPC       = 8,
  parameter int         PIPE      = 1,
  parameter logic [7:0] RESET_CFG = 8'h10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     cfg_in,
  input  logic           cfg_load,
  output logic           cfg_pending,
  input  logic [7:0]     pix_in,
  input  logic [9:0]     hpos,
  input  logic [9:0]     vpos,
  input  logic           visible,
  input  logic           vmax,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic [BPC-1:0] r,
  output logic [BPC-1:0] g,
  output logic [BPC-1:0] b,
  output logic [7:0]     frame
);

  import pattern_gen_pkg::*;

  logic [7:0] cfg_act_q,  cfg_act_d;
  logic [7:0] cfg_pend_q, cfg_pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] frame_q,    frame_d;

  // Config handshake and frame counter next state
  always_comb begin
    cfg_act_d  = cfg_act_q;
    cfg_pend_d = cfg_pend_q;
    pend_vld_d = pend_vld_q;
    if (cfg_load && vmax) begin
      // Load on the boundary itself goes live at once; any older pending is dropped
      cfg_act_d  = cfg_in;
      pend_vld_d = 1'b0;
    end else if (cfg_load) begin
      cfg_pend_d = cfg_in;
      pend_vld_d = 1'b1;
    end else if (vmax && pend_vld_q) begin
      cfg_act_d  = cfg_pend_q;
      pend_vld_d = 1'b0;
    end
    frame_d = vmax ? frame_q + 8'd1 : frame_q;
  end

  // Config and frame state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_act_q  <= RESET_CFG;
      cfg_pend_q <= 8'h00;
      pend_vld_q <= 1'b0;
      frame_q    <= 8'h00;
    end else begin
      cfg_act_q  <= cfg_act_d;
      cfg_pend_q <= cfg_pend_d;
      pend_vld_q <= pend_vld_d;
      frame_q    <= frame_d;
    end
  end

  assign cfg_pending = pend_vld_q;
  assign frame       = frame_q;

  logic [2:0] mode_w;
  logic [1:0] div_w;
  logic [1:0] pri_w;
  logic [7:0] h8_w, v8_w, ra_w;
  logic [2:0] bar_idx_w, bar_rgb_w;
  logic       chk_p_w;

  assign mode_w    = cfg_act_q[CFG_MODE_MSB:CFG_MODE_LSB];
  assign div_w     = cfg_act_q[CFG_DIV_MSB:CFG_DIV_LSB];
  assign pri_w     = cfg_act_q[CFG_PRI_MSB:CFG_PRI_LSB];
  assign h8_w      = hpos[7:0];
  assign v8_w      = vpos[7:0];
  assign ra_w      = 8'(hpos >> div_w);
  assign bar_idx_w = 3'(hpos >> (4'd6 + {2'b00, div_w}));
  assign bar_rgb_w = bar_colour(bar_idx_w);
  assign chk_p_w   = 1'((hpos ^ vpos) >> (4'd3 + {2'b00, div_w}));

  logic [7:0] pat_r_w, pat_g_w, pat_b_w;

  // 8-bit-per-channel pattern selected by the active config
  always_comb begin
    pat_r_w = 8'h00;
    pat_g_w = 8'h00;
    pat_b_w = 8'h00;
    case (mode_w)
      MODE_PASS: begin
        pat_r_w = pix_in;
        pat_g_w = pix_in;
        pat_b_w = pix_in;
      end
      MODE_RAMP: begin
        case (pri_w)
          2'd0:    {pat_r_w, pat_g_w, pat_b_w} = {ra_w, v8_w, frame_q};
          2'd1:    {pat_r_w, pat_g_w, pat_b_w} = {frame_q, ra_w, v8_w};
          2'd2:    {pat_r_w, pat_g_w, pat_b_w} = {v8_w, frame_q, ra_w};
          default: {pat_r_w, pat_g_w, pat_b_w} = {ra_w, ra_w, ra_w};
        endcase
      end
      MODE_BARS: begin
        case (pri_w)
          // Channel check: one bar bit replicated onto all three channels
          2'd0:    {pat_r_w, pat_g_w, pat_b_w} = {3{{8{bar_rgb_w[2]}}}};
          2'd1:    {pat_r_w, pat_g_w, pat_b_w} = {3{{8{bar_rgb_w[1]}}}};
          2'd2:    {pat_r_w, pat_g_w, pat_b_w} = {3{{8{bar_rgb_w[0]}}}};
          default: {pat_r_w, pat_g_w, pat_b_w} =
                     {{8{bar_rgb_w[2]}}, {8{bar_rgb_w[1]}}, {8{bar_rgb_w[0]}}};
        endcase
      end
      MODE_XORS: begin
        pat_r_w = h8_w ^ v8_w;
        pat_g_w = h8_w & v8_w;
        pat_b_w = h8_w - v8_w + frame_q;
      end
      MODE_CHECK: begin
        if (chk_p_w) begin
          pat_r_w = (pri_w == 2'd0 || pri_w == 2'd3) ? 8'hFF : 8'h00;
          pat_g_w = (pri_w == 2'd1 || pri_w == 2'd3) ? 8'hFF : 8'h00;
          pat_b_w = (pri_w == 2'd2 || pri_w == 2'd3) ? 8'hFF : 8'h00;
        end
      end
      default: ;
    endcase
  end

  logic [7:0] dith_r_w, dith_g_w, dith_b_w;

`ifdef PATTERN_GEN_DITHER_EN
  generate
    if (BPC < 8) begin : g_dither
      logic [1:0] d_w;
      logic [9:0] add_w;
      logic       en_w;
      assign d_w   = bayer_val({vpos[0], hpos[0]});
      // Threshold scaled to a quarter of one output LSB step
      assign add_w = ({8'd0, d_w} << (8 - BPC)) >> 2;
      assign en_w  = (mode_w != MODE_PASS);
      assign dith_r_w = en_w ? sat_add8(pat_r_w, add_w) : pat_r_w;
      assign dith_g_w = en_w ? sat_add8(pat_g_w, add_w) : pat_g_w;
      assign dith_b_w = en_w ? sat_add8(pat_b_w, add_w) : pat_b_w;
    end else begin : g_no_dither
      assign dith_r_w = pat_r_w;
      assign dith_g_w = pat_g_w;
      assign dith_b_w = pat_b_w;
    end
  endgenerate
`else
  assign dith_r_w = pat_r_w;
  assign dith_g_w = pat_g_w;
  assign dith_b_w = pat_b_w;
`endif

  logic [3*BPC-1:0] rgb_d_w, rgb_q_w;
  logic [2:0]       sync_q_w;

  // Keep the top BPC bits and black out everything outside active video
  assign rgb_d_w = visible ? {dith_r_w[7 -: BPC], dith_g_w[7 -: BPC], dith_b_w[7 -: BPC]}
                           : '0;

  pattern_pipe #(
    .W       (3*BPC),
    .DEPTH   (PIPE),
    .RST_VAL ({(3*BPC){1'b0}})
  ) u_rgb_pipe (
    .clk   (clk),
    .reset (reset),
    .d_i   (rgb_d_w),
    .q_o   (rgb_q_w)
  );

  // Blank resets high so the output reads as blanked until real video arrives
  pattern_pipe #(
    .W       (3),
    .DEPTH   (PIPE),
    .RST_VAL (3'b001)
  ) u_sync_pipe (
    .clk   (clk),
    .reset (reset),
    .d_i   ({hsync_in, vsync_in, ~visible}),
    .q_o   (sync_q_w)
  );

  assign r     = rgb_q_w[3*BPC-1 -: BPC];
  assign g     = rgb_q_w[2*BPC-1 -: BPC];
  assign b     = rgb_q_w[BPC-1:0];
  assign hsync = sync_q_w[2];
  assign vsync = sync_q_w[1];
  assign blank = sync_q_w[0];

  // Reserved config bit and truncated-away low bits have no consumer
  logic unused_w;
  assign unused_w = ^{cfg_act_q[7], dith_r_w, dith_g_w, dith_b_w};

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_gen
// Description : Scoreboard bench for pattern_gen. Three instances share the
//               stimulus: BPC=8/PIPE=1, BPC=8/PIPE=3 and BPC=4/PIPE=1.
//               Dither expectations follow PATTERN_GEN_DITHER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_in;
  logic       cfg_load;
  logic [7:0] pix_in;
  logic [9:0] hpos, vpos;
  logic       visible, vmax, hsync_in, vsync_in;

  logic       p0, p3, p4;
  logic       hs0, hs3, hs4, vs0, vs3, vs4, bl0, bl3, bl4;
  logic [7:0] r0, g0, b0, r3, g3, b3;
  logic [3:0] r4, g4, b4;
  logic [7:0] f0, f3, f4;

  int checks = 0;
  int passed = 0;

  logic [23:0] q0[$];
  logic [23:0] q3[$];
  logic [12:0] q4[$];   // {check_enable, r4, g4, b4}

  always #5 clk = ~clk;

  pattern_gen #(.BPC(8), .PIPE(1), .RESET_CFG(8'h10)) u0 (
    .clk(clk), .reset(reset), .cfg_in(cfg_in), .cfg_load(cfg_load), .cfg_pending(p0),
    .pix_in(pix_in), .hpos(hpos), .vpos(vpos), .visible(visible), .vmax(vmax),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hs0), .vsync(vs0), .blank(bl0),
    .r(r0), .g(g0), .b(b0), .frame(f0));

  pattern_gen #(.BPC(8), .PIPE(3), .RESET_CFG(8'h10)) u3 (
    .clk(clk), .reset(reset), .cfg_in(cfg_in), .cfg_load(cfg_load), .cfg_pending(p3),
    .pix_in(pix_in), .hpos(hpos), .vpos(vpos), .visible(visible), .vmax(vmax),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hs3), .vsync(vs3), .blank(bl3),
    .r(r3), .g(g3), .b(b3), .frame(f3));

  pattern_gen #(.BPC(4), .PIPE(1), .RESET_CFG(8'h10)) u4 (
    .clk(clk), .reset(reset), .cfg_in(cfg_in), .cfg_load(cfg_load), .cfg_pending(p4),
    .pix_in(pix_in), .hpos(hpos), .vpos(vpos), .visible(visible), .vmax(vmax),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hs4), .vsync(vs4), .blank(bl4),
    .r(r4), .g(g4), .b(b4), .frame(f4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus; expected pixel pushed when visible
  task automatic px(input logic [9:0] h, input logic [9:0] v, input logic vis,
                    input logic [7:0] pix, input logic ld, input logic [7:0] cfg,
                    input logic vm, input logic [23:0] e8, input logic [11:0] e4,
                    input logic c4);
    hpos = h; vpos = v; visible = vis; pix_in = pix;
    cfg_load = ld; cfg_in = cfg; vmax = vm;
    if (vis) begin
      q0.push_back(e8);
      q3.push_back(e8);
      q4.push_back({c4, e4});
    end
    @(negedge clk);
    cfg_load = 1'b0; vmax = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 12'h0, 1'b0);
  endtask

  // Monitors: one pixel popped per unblanked output cycle
  always @(negedge clk) begin
    if (!reset && !bl0) begin
      if (q0.size() == 0) chk("u0_underflow", 32'd1, 32'd0);
      else chk("u0_rgb", {8'h0, r0, g0, b0}, {8'h0, q0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!reset && !bl3) begin
      if (q3.size() == 0) chk("u3_underflow", 32'd1, 32'd0);
      else chk("u3_rgb", {8'h0, r3, g3, b3}, {8'h0, q3.pop_front()});
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (!reset && !bl4) begin
      if (q4.size() == 0) chk("u4_underflow", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        if (e[12]) chk("u4_rgb", {20'h0, r4, g4, b4}, {20'h0, e[11:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] e4_dith;
    reset = 1'b1; cfg_in = 8'h00; cfg_load = 1'b0; pix_in = 8'h00;
    hpos = 10'd37; vpos = 10'd5; visible = 1'b1; vmax = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state while visible is driven high
    chk("rst_rgb",   {8'h0, r0, g0, b0}, 32'h0);
    chk("rst_blank", {29'h0, bl0, hs0, vs0}, 32'h4);
    chk("rst_frame", {24'h0, f0}, 32'h0);
    chk("rst_pend",  {31'h0, p0}, 32'h0);
    chk("rst_blank3", {31'h0, bl3}, 32'h1);
    reset = 1'b0;

    // Reset config RAMP red: {ra, v8, frame}
    px(10'd37, 10'd5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, {8'd37, 8'd5, 8'd0}, 12'h0, 1'b0);
    chk("pend_idle", {31'h0, p0}, 32'h0);
    px(10'd40, 10'd5, 1'b1, 8'h00, 1'b1, 8'h23, 1'b0, {8'd40, 8'd5, 8'd0}, 12'h0, 1'b0);
    chk("pend_set", {31'h0, p0}, 32'h1);
    px(10'd41, 10'd5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, {8'd41, 8'd5, 8'd0}, 12'h0, 1'b0);
    px(10'd0, 10'd5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("pend_applied", {31'h0, p0}, 32'h0);
    chk("frame1", {24'h0, f0}, 32'd1);

    // BARS full colour: yellow, green, black
    px(10'd70,  10'd6, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'hFFFF00, 12'h0, 1'b0);
    px(10'd200, 10'd6, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h00FF00, 12'h0, 1'b0);
    px(10'd500, 10'd6, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 12'h0, 1'b0);

    // Stale pending is discarded by a load coinciding with vmax
    px(10'd0, 10'd6, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 24'h0, 12'h0, 1'b0);
    chk("pend_set2", {31'h0, p0}, 32'h1);
    px(10'd0, 10'd6, 1'b0, 8'h00, 1'b1, 8'h30, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("pend_direct", {31'h0, p0}, 32'h0);
    chk("frame2", {24'h0, f0}, 32'd2);

    // XORS with frame=2
    px(10'd12, 10'd10, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h060804, 12'h0, 1'b0);
    px(10'd3,  10'd5,  1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h060100, 12'h0, 1'b0);

    // Last load wins: 0x44 then 0x45 (CHECKER, divider 1, green)
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 24'h0, 12'h0, 1'b0);
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'h45, 1'b0, 24'h0, 12'h0, 1'b0);
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("frame3", {24'h0, f0}, 32'd3);
    px(10'd16, 10'd0,  1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h00FF00, 12'h0, 1'b0);
    px(10'd16, 10'd16, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 12'h0, 1'b0);
    px(10'd8,  10'd0,  1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 12'h0, 1'b0);

    // PASS: BPC=4 keeps the top nibble, never dithered
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    px(10'd5, 10'd5, 1'b1, 8'hB7, 1'b0, 8'h00, 1'b0, 24'hB7B7B7, 12'hBBB, 1'b1);

    // RAMP all-channel, divider 1: ra = hpos>>1
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'h17, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("frame5", {24'h0, f0}, 32'd5);
    px(10'h1F1, 10'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'hF8F8F8, 12'hFFF, 1'b1);
`ifdef PATTERN_GEN_DITHER_EN
    e4_dith = 12'hFFF;
`else
    e4_dith = 12'hEEE;
`endif
    px(10'h1D1, 10'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'hE8E8E8, e4_dith, 1'b1);
    idle(4);

    // PIPE=3 alignment: blank and hsync move together 3 clocks later
    hsync_in = 1'b1;
    px(10'd10, 10'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h050505, 12'h0, 1'b0);
    chk("u0_hsync_d1", {31'h0, hs0}, 32'h1);
    chk("u3_blank_d1", {30'h0, bl3, hs3}, 32'h2);
    hsync_in = 1'b0;
    idle(1);
    chk("u3_blank_d2", {30'h0, bl3, hs3}, 32'h2);
    chk("u3_rgb_blanked", {8'h0, r3, g3, b3}, 32'h0);
    idle(1);
    chk("u3_blank_d3", {30'h0, bl3, hs3}, 32'h1);
    idle(4);

    // Frame counter wrap
    for (int i = 0; i < 250; i++) px(10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("frame255", {24'h0, f0}, 32'd255);
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    chk("frame_wrap", {24'h0, f0}, 32'd0);
    px(10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);

    // Asynchronous reset mid-frame with a pending config and live pixels
    px(10'd20, 10'd0, 1'b1, 8'h00, 1'b1, 8'h30, 1'b0, 24'h0A0A0A, 12'h0, 1'b0);
    px(10'd22, 10'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0B0B0B, 12'h0, 1'b0);
    chk("pre_rst_pend", {31'h0, p0}, 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rgb",   {8'h0, r0, g0, b0}, 32'h0);
    chk("arst_blank", {30'h0, bl0, bl3}, 32'h3);
    chk("arst_frame", {24'h0, f0}, 32'h0);
    chk("arst_pend",  {31'h0, p0}, 32'h0);
    q0.delete(); q3.delete(); q4.delete();
    @(negedge clk);
    reset = 1'b0;
    px(10'd37, 10'd5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, {8'd37, 8'd5, 8'd0}, 12'h0, 1'b0);
    px(10'd0, 10'd5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'h0, 12'h0, 1'b0);
    px(10'd37, 10'd5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, {8'd37, 8'd5, 8'd1}, 12'h0, 1'b0);
    idle(5);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
